// File: rtl/fifo_uart_packet_tx.sv
// fifo_uart_packet_tx: drains the packet FIFO and sends each packet on an
// 8N1 UART line (LSB first) as SOF, payload bytes, XOR checksum, EOF.
//
// state      | meaning
// IDLE       | line idle; checksum and count cleared; waits for enable and data
// SEND_SOF   | serializing the start-of-frame byte
// FETCH      | one-cycle FIFO read strobe (skipped to SEND_CHK if FIFO empty)
// WAIT_DATA  | waiting up to 2 cycles for the popped byte to arrive
// SEND_DATA  | serializing a payload byte
// SEND_CHK   | serializing the XOR checksum of the payload
// SEND_EOF   | serializing the end-of-frame byte; pkt_done on its last cycle
module fifo_uart_packet_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         MAX_PAYLOAD  = 8,
  parameter logic [7:0] SOF_BYTE     = 8'hA5,
  parameter logic [7:0] EOF_BYTE     = 8'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  output logic       fifo_rden,
  input  logic [7:0] fifo_data,
  input  logic       fifo_data_valid,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done,
  output logic [7:0] pkt_len
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]        MAX_LEN   = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE, SEND_SOF, FETCH, WAIT_DATA, SEND_DATA, SEND_CHK, SEND_EOF
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wait_q, wait_d;
  logic [7:0]        len_q, len_d;
  logic              tx_q, tx_d;
  logic              in_byte, bit_end, byte_done;
  logic [2:0]        data_idx;

  // State, counters and the registered TX line; reset drives tx high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      len_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
    end
  end

  // Shared bit timing for all byte states plus the packet sequencing.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    len_d   = len_q;

    in_byte   = (state_q == SEND_SOF) || (state_q == SEND_DATA) ||
                (state_q == SEND_CHK) || (state_q == SEND_EOF);
    bit_end   = in_byte && (baud_q == BAUD_LAST);
    byte_done = bit_end && (bit_q == 4'd9);

    // Counters wrap to zero at the end of each byte so the next byte state
    // always starts at the beginning of its start bit.
    if (in_byte) begin
      if (bit_end) begin
        baud_d = '0;
        bit_d  = byte_done ? 4'd0 : bit_q + 4'd1;
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        chk_d  = '0;
        cnt_d  = '0;
        wait_d = 1'b0;
        if (enable && !fifo_empty) begin
          state_d = SEND_SOF;
          byte_d  = SOF_BYTE;
        end
      end
      SEND_SOF: begin
        if (byte_done) state_d = FETCH;
      end
      FETCH: begin
        wait_d = 1'b0;
        if (fifo_empty) begin
          state_d = SEND_CHK;
          byte_d  = chk_q;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (fifo_data_valid) begin
          byte_d  = fifo_data;
          chk_d   = chk_q ^ fifo_data;
          cnt_d   = cnt_q + 8'd1;
          state_d = SEND_DATA;
        end else if (wait_q) begin
          state_d = SEND_CHK;
          byte_d  = chk_q;
        end else begin
          wait_d = 1'b1;
        end
      end
      SEND_DATA: begin
        if (byte_done) begin
          if ((cnt_q == MAX_LEN) || fifo_empty) begin
            state_d = SEND_CHK;
            byte_d  = chk_q;
          end else begin
            state_d = FETCH;
          end
        end
      end
      SEND_CHK: begin
        if (byte_done) begin
          state_d = SEND_EOF;
          byte_d  = EOF_BYTE;
        end
      end
      SEND_EOF: begin
        if (byte_done) begin
          state_d = IDLE;
          len_d   = cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the next cycle, derived from the next-state view so tx is a clean flop.
  always_comb begin
    data_idx = 3'(bit_d - 4'd1);
    tx_d     = 1'b1;
    if ((state_d == SEND_SOF) || (state_d == SEND_DATA) ||
        (state_d == SEND_CHK) || (state_d == SEND_EOF)) begin
      if (bit_d == 4'd0)      tx_d = 1'b0;
      else if (bit_d == 4'd9) tx_d = 1'b1;
      else                    tx_d = byte_d[data_idx];
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign fifo_rden = (state_q == FETCH) && !fifo_empty;
  assign pkt_done  = (state_q == SEND_EOF) && byte_done;
  assign pkt_len   = len_q;

endmodule

// File: tb/tb_fifo_uart_packet_tx.sv
// Bench for fifo_uart_packet_tx: FIFO model, UART line decoder and a
// packet-level reference model built from the framing rules.
module tb_fifo_uart_packet_tx;

  localparam int         CPB      = 4;
  localparam int         MAXP     = 8;
  localparam logic [7:0] SOF      = 8'hA5;
  localparam logic [7:0] EOF      = 8'h5A;
  localparam int         BYTE_CYC = 10 * CPB;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic       fifo_rden;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_data_valid = 1'b0;
  logic       tx;
  logic       busy;
  logic       pkt_done;
  logic [7:0] pkt_len;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_uart_packet_tx #(
    .CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MAXP), .SOF_BYTE(SOF), .EOF_BYTE(EOF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rden(fifo_rden), .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid),
    .tx(tx), .busy(busy), .pkt_done(pkt_done), .pkt_len(pkt_len)
  );

  // FIFO model: data and valid one cycle after the read strobe.
  logic [7:0] fmem [64];
  logic [5:0] wp = 6'd0;
  logic [5:0] rp = 6'd0;
  logic [6:0] fcnt = 7'd0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  int         underflow = 0;

  always @(posedge clk) begin
    if (wr_en) begin
      fmem[wp] <= wr_data;
      wp <= wp + 6'd1;
    end
    if (fifo_rden) begin
      if (fcnt == 7'd0) underflow <= underflow + 1;
      fifo_data <= fmem[rp];
      rp <= rp + 6'd1;
    end
    fifo_data_valid <= fifo_rden && (fcnt != 7'd0);
    fcnt <= fcnt + 7'(wr_en) - 7'(fifo_rden && (fcnt != 7'd0));
  end
  assign fifo_empty = (fcnt == 7'd0);

  // Event counters and pkt_len log (pkt_len sampled the cycle after pkt_done).
  int   rden_cnt = 0, done_cnt = 0, tx_low_cnt = 0;
  bq_t  len_log;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (fifo_rden === 1'b1) rden_cnt <= rden_cnt + 1;
    if (pkt_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
    if (done_prev) len_log.push_back(pkt_len);
    done_prev <= (pkt_done === 1'b1);
  end

  // UART line decoder: every bit must be stable for exactly CPB cycles.
  bq_t        rx_q;
  int         rx_err = 0;
  int         gap_max = 0;
  logic       smp [BYTE_CYC];
  initial begin
    int   gap;
    logic gap_on, aborted, bad;
    logic [7:0] d;
    gap = 0;
    gap_on = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gap_on = 1'b0;
      end else if (tx === 1'b0) begin
        if (gap_on && gap > gap_max) gap_max = gap;
        aborted = 1'b0;
        for (int i = 0; i < BYTE_CYC && !aborted; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          else smp[i] = tx;
        end
        if (!aborted) begin
          bad = 1'b0;
          for (int b = 0; b < 10; b++)
            for (int k = 0; k < CPB; k++)
              if (smp[b*CPB+k] !== smp[b*CPB]) bad = 1'b1;
          if (smp[0] !== 1'b0 || smp[9*CPB] !== 1'b1) bad = 1'b1;
          for (int b = 0; b < 8; b++) d[b] = smp[(b+1)*CPB];
          if (bad) rx_err = rx_err + 1;
          rx_q.push_back(d);
          gap_on = busy;
          gap = 0;
        end else begin
          gap_on = 1'b0;
        end
      end else if (gap_on) begin
        if (busy === 1'b1) gap = gap + 1;
        else gap_on = 1'b0;
      end
    end
  end

  // Reference model: split payload into packets of at most MAXP bytes.
  task automatic build_expected(input bq_t data, output bq_t exp, output bq_t lens);
    int idx, n;
    logic [7:0] chk;
    exp = {};
    lens = {};
    idx = 0;
    while (idx < data.size()) begin
      n = data.size() - idx;
      if (n > MAXP) n = MAXP;
      chk = 8'h00;
      exp.push_back(SOF);
      for (int k = 0; k < n; k++) begin
        exp.push_back(data[idx+k]);
        chk = chk ^ data[idx+k];
      end
      exp.push_back(chk);
      exp.push_back(EOF);
      lens.push_back(8'(n));
      idx = idx + n;
    end
  endtask

  task automatic push_bytes(input bq_t data);
    foreach (data[i]) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = data[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int c = 0; c < budget && done_cnt < target; c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx_in_reset: got %b expected 1", tx); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (pkt_done !== 1'b0) begin n_err++; $display("FAIL reset_pkt_done: got %b expected 0", pkt_done); end
    n_vec++; if (fifo_rden !== 1'b0) begin n_err++; $display("FAIL reset_rden: got %b expected 0", fifo_rden); end
    n_vec++; if (pkt_len !== 8'h00) begin n_err++; $display("FAIL reset_pkt_len: got %0h expected 0", pkt_len); end
    begin
      int r0, t0;
      r0 = rden_cnt;
      t0 = tx_low_cnt;
      enable = 1'b1;
      repeat (200) @(negedge clk);
      n_vec++; if (rden_cnt != r0) begin n_err++; $display("FAIL idle_rden: got %0d pulses expected 0", rden_cnt - r0); end
      n_vec++; if (tx_low_cnt != t0) begin n_err++; $display("FAIL idle_tx: got %0d low cycles expected 0", tx_low_cnt - t0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
      enable = 1'b0;
    end
  endtask

  // Preload the FIFO with enable low, then let the packets drain.
  task automatic test_stream(input string name, input bq_t data);
    bq_t exp, lens;
    int rx0, len0, d0, r0, e0, u0;
    build_expected(data, exp, lens);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rx0 = rx_q.size(); len0 = len_log.size(); d0 = done_cnt; r0 = rden_cnt; e0 = rx_err; u0 = underflow;
    push_bytes(data);
    enable = 1'b1;
    wait_done(d0 + lens.size(), (exp.size() + 2) * BYTE_CYC * 2 + 100);
    enable = 1'b0;
    n_vec++; if (done_cnt - d0 != lens.size()) begin n_err++; $display("FAIL %s_pkt_done: got %0d expected %0d", name, done_cnt - d0, lens.size()); end
    n_vec++; if (rx_q.size() - rx0 != exp.size()) begin n_err++; $display("FAIL %s_byte_count: got %0d expected %0d", name, rx_q.size() - rx0, exp.size()); end
    for (int i = 0; i < exp.size() && rx0 + i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[rx0+i] !== exp[i]) begin n_err++; $display("FAIL %s_byte[%0d]: got %0h expected %0h", name, i, rx_q[rx0+i], exp[i]); end
    end
    for (int i = 0; i < lens.size() && len0 + i < len_log.size(); i++) begin
      n_vec++; if (len_log[len0+i] !== lens[i]) begin n_err++; $display("FAIL %s_pkt_len[%0d]: got %0d expected %0d", name, i, len_log[len0+i], lens[i]); end
    end
    n_vec++; if (rden_cnt - r0 != data.size()) begin n_err++; $display("FAIL %s_rden: got %0d expected %0d", name, rden_cnt - r0, data.size()); end
    n_vec++; if (rx_err != e0) begin n_err++; $display("FAIL %s_bit_timing: got %0d bad bytes expected 0", name, rx_err - e0); end
    n_vec++; if (underflow != u0) begin n_err++; $display("FAIL %s_underflow: got %0d expected 0", name, underflow - u0); end
    n_vec++; if (gap_max > 4) begin n_err++; $display("FAIL %s_gap: got %0d expected <=4", name, gap_max); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_end: got %b expected 0", name, busy); end
  endtask

  task automatic test_reset_mid_packet();
    bq_t data, rem, exp, lens;
    int rx0, rx1, d1;
    data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rem  = '{8'h33, 8'h44, 8'h55};
    build_expected(rem, exp, lens);
    enable = 1'b0;
    rx0 = rx_q.size();
    push_bytes(data);
    enable = 1'b1;
    for (int c = 0; c < 4 * BYTE_CYC && rx_q.size() < rx0 + 2; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    rx1 = rx_q.size();
    d1 = done_cnt;
    n_vec++; if (rx1 - rx0 != 2) begin n_err++; $display("FAIL midrst_pre_bytes: got %0d expected 2", rx1 - rx0); end
    wait_done(d1 + 1, (exp.size() + 2) * BYTE_CYC * 2);
    enable = 1'b0;
    n_vec++; if (rx_q.size() - rx1 != exp.size()) begin n_err++; $display("FAIL midrst_byte_count: got %0d expected %0d", rx_q.size() - rx1, exp.size()); end
    for (int i = 0; i < exp.size() && rx1 + i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[rx1+i] !== exp[i]) begin n_err++; $display("FAIL midrst_byte[%0d]: got %0h expected %0h", i, rx_q[rx1+i], exp[i]); end
    end
    n_vec++; if (pkt_len !== lens[0]) begin n_err++; $display("FAIL midrst_pkt_len: got %0d expected %0d", pkt_len, lens[0]); end
  endtask

  task automatic test_enable();
    bq_t data, exp, lens;
    int r0, t0, rx0, d0;
    data = '{8'hC3, 8'h3C};
    build_expected(data, exp, lens);
    enable = 1'b0;
    push_bytes(data);
    r0 = rden_cnt; t0 = tx_low_cnt;
    repeat (50) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_off_busy: got %b expected 0", busy); end
    n_vec++; if (rden_cnt != r0 || tx_low_cnt != t0) begin n_err++; $display("FAIL en_off_activity: got %0d rden %0d low expected 0 0", rden_cnt - r0, tx_low_cnt - t0); end
    rx0 = rx_q.size(); d0 = done_cnt;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b1 || tx !== 1'b0) begin n_err++; $display("FAIL en_start: got busy=%b tx=%b expected busy=1 tx=0", busy, tx); end
    enable = 1'b0;
    wait_done(d0 + 1, (exp.size() + 2) * BYTE_CYC * 2);
    n_vec++; if (rx_q.size() - rx0 != exp.size()) begin n_err++; $display("FAIL en_drop_byte_count: got %0d expected %0d", rx_q.size() - rx0, exp.size()); end
    for (int i = 0; i < exp.size() && rx0 + i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[rx0+i] !== exp[i]) begin n_err++; $display("FAIL en_drop_byte[%0d]: got %0h expected %0h", i, rx_q[rx0+i], exp[i]); end
    end
    n_vec++; if (pkt_len !== 8'd2) begin n_err++; $display("FAIL en_drop_pkt_len: got %0d expected 2", pkt_len); end
    data = '{8'h99};
    push_bytes(data);
    r0 = rden_cnt;
    repeat (60) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || rden_cnt != r0) begin n_err++; $display("FAIL en_hold: got busy=%b rden=%0d expected busy=0 rden=0", busy, rden_cnt - r0); end
    rx0 = rx_q.size(); d0 = done_cnt;
    enable = 1'b1;
    wait_done(d0 + 1, 6 * BYTE_CYC * 2);
    enable = 1'b0;
    build_expected(data, exp, lens);
    n_vec++; if (rx_q.size() - rx0 != exp.size()) begin n_err++; $display("FAIL en_resume_byte_count: got %0d expected %0d", rx_q.size() - rx0, exp.size()); end
    for (int i = 0; i < exp.size() && rx0 + i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[rx0+i] !== exp[i]) begin n_err++; $display("FAIL en_resume_byte[%0d]: got %0h expected %0h", i, rx_q[rx0+i], exp[i]); end
    end
  endtask

  task automatic test_late_write();
    bq_t first, late, all, exp, lens;
    int rx0, d0;
    first = '{8'h77};
    late  = '{8'h88};
    all   = '{8'h77, 8'h88};
    build_expected(all, exp, lens);
    enable = 1'b0;
    push_bytes(first);
    rx0 = rx_q.size(); d0 = done_cnt;
    enable = 1'b1;
    for (int c = 0; c < 10 && busy !== 1'b1; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    push_bytes(late);
    wait_done(d0 + 1, (exp.size() + 2) * BYTE_CYC * 2);
    enable = 1'b0;
    n_vec++; if (rx_q.size() - rx0 != exp.size()) begin n_err++; $display("FAIL late_byte_count: got %0d expected %0d", rx_q.size() - rx0, exp.size()); end
    for (int i = 0; i < exp.size() && rx0 + i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[rx0+i] !== exp[i]) begin n_err++; $display("FAIL late_byte[%0d]: got %0h expected %0h", i, rx_q[rx0+i], exp[i]); end
    end
    n_vec++; if (pkt_len !== lens[0]) begin n_err++; $display("FAIL late_pkt_len: got %0d expected %0d", pkt_len, lens[0]); end
  endtask

  initial begin
    bq_t data;
    test_reset();
    data = '{8'h12, 8'h34};
    test_stream("two_bytes", data);
    data = {};
    for (int i = 1; i <= 10; i++) data.push_back(8'(i));
    test_stream("max_payload", data);
    test_reset_mid_packet();
    test_enable();
    test_late_write();
    for (int it = 0; it < 5; it++) begin
      data = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) data.push_back(8'($urandom));
      test_stream("random", data);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_packet_tx.md
Name: fifo_uart_packet_tx

Overview:
- Reader and transmit end of the UART packetizer path.
- Drains bytes from the 8x8 FIFO through its read port and emits them on a serial UART line (8N1, LSB first) as framed packets: SOF, payload bytes, XOR checksum, EOF.
- Sits between the FIFO read side and the board TX pin; the write side of the FIFO is owned by the packetizer.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
- MAX_PAYLOAD, 8, maximum payload bytes per packet (1..255).
- SOF_BYTE, 8'hA5, start-of-frame byte.
- EOF_BYTE, 8'h5A, end-of-frame byte.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new packet starts; a packet in progress always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rden  output  1  single-cycle FIFO read strobe.
- fifo_data  input  8  FIFO DataOut.
- fifo_data_valid  input  1  FIFO data_out_valid; qualifies fifo_data.
- tx  output  1  UART serial output, idle high.
- busy  output  1  high from SOF start-bit launch until the EOF stop bit ends.
- pkt_done  output  1  one-cycle pulse on the final cycle of the EOF stop bit.
- pkt_len  output  8  payload count of the last completed packet; holds until the next pkt_done.

Behaviour:
- Reset (async assert, sync release) gives:
  - tx=1, busy=0, pkt_done=0, fifo_rden=0, pkt_len=0.
  - FSM=IDLE; all counters and the checksum cleared.
- Reset mid-packet aborts immediately, with tx forced high in the same instant. A byte already popped but not yet sent is discarded.
- Byte serializer, shared by all byte states:
  - Start bit (0), then 8 data bits LSB first, then stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, so one byte is 10*CLKS_PER_BIT cycles.
  - Bit counter 0..9; baud counter 0..CLKS_PER_BIT-1, reset at every bit boundary.
- FSM states: IDLE, SEND_SOF, FETCH, WAIT_DATA, SEND_DATA, SEND_CHK, SEND_EOF.
- IDLE:
  - If enable=1 and fifo_empty=0: next cycle enter SEND_SOF, start bit begins on tx, busy=1.
  - Clear checksum to 8'h00 and payload count to 0.
- SEND_SOF: on completion of the SOF stop bit go to FETCH.
- FETCH:
  - Assert fifo_rden for exactly one cycle, then go to WAIT_DATA.
  - fifo_rden is never asserted while fifo_empty=1 or while a read is outstanding.
- WAIT_DATA:
  - On the first cycle fifo_data_valid=1: capture fifo_data, checksum ^= data, count += 1, go to SEND_DATA.
  - If no valid arrives within 2 cycles after the rden cycle: abandon that read, go to SEND_CHK. Count is not incremented.
- SEND_DATA, after the stop bit:
  - If count==MAX_PAYLOAD or fifo_empty=1: go to SEND_CHK.
  - Else go to FETCH.
  - Inter-byte gap is idle-high and at most 4 cycles.
- SEND_CHK: send the accumulated checksum byte, then go to SEND_EOF.
- SEND_EOF:
  - Send EOF_BYTE.
  - On its last stop-bit cycle: pkt_done=1 and pkt_len=count.
  - Next cycle: busy=0, FSM=IDLE.
  - A new packet may start on the following cycle, so back-to-back packets are allowed.
- Bytes written to the FIFO during a packet are picked up by that packet, provided fifo_empty is 0 at the post-byte decision point and MAX_PAYLOAD is not yet reached.
- enable dropping mid-packet has no effect until IDLE.
- Payload count is 8-bit and never wraps, since MAX_PAYLOAD ≤ 255. Checksum is a plain 8-bit XOR.
- Payload bytes equal to SOF/EOF are sent unescaped; framing relies on the checksum.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset then idle, FIFO empty -> tx=1, busy=0, fifo_rden never asserted for 200 cycles.
- FIFO preloaded with 0x12, 0x34 -> line carries A5 12 34 26 5A. Each byte is exactly 40 cycles; pkt_len=2; exactly one pkt_done pulse; exactly 2 rden pulses.
- FIFO preloaded with 10 bytes 0x01..0x0A, MAX_PAYLOAD=8 -> first packet is A5 01..08 08 5A with pkt_len=8. A second packet follows immediately: A5 09 0A 03 5A, pkt_len=2.
- rst_n pulsed low for 1 cycle in the middle of the second payload byte -> tx=1 asynchronously, busy=0 at once. After release, a fresh packet begins with SOF using the next FIFO byte.
- enable=0 with FIFO non-empty -> no activity. Raising enable starts SOF within 2 cycles.
- FIFO holding 1 byte 0x77; a second byte 0x88 written during SOF transmission -> packet is A5 77 88 FF 5A, pkt_len=2.
